// File: rtl/pr3_frame_streamer_if.sv
// Output packet stream of pr3_frame_streamer: Avalon-ST style beats, no backpressure.
interface pr3_frame_streamer_if;
  logic        source_valid;
  logic        source_sop;
  logic        source_eop;
  logic [31:0] source_data;

  modport master (output source_valid, source_sop, source_eop, source_data);
  modport slave  (input  source_valid, source_sop, source_eop, source_data);
endinterface

// File: rtl/pr3_frame_streamer.sv
// Round-robin framer: cuts 2^FFT-sample frames from NSINK ADC channels every PERIOD cycles.
// Optional macro PR3_CHTAG_EN puts the channel index in source_data[7:0].
module pr3_fs_lane #(
  parameter int WIDTH = 14
) (
  input  logic             clk40,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk40) begin
    if (!reset) q <= '0;
    else        q <= d;
  end
endmodule

module pr3_frame_streamer #(
  parameter int NSINK  = 3,
  parameter int WIDTH  = 14,
  parameter int FFT    = 11,
  parameter int FREQ   = 5000,
  parameter int CLK_HZ = 40000000
) (
  input  logic                    clk40,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] sink [0:NSINK-1],
  pr3_frame_streamer_if.master    src
);
  localparam int FLEN   = 1 << FFT;
  localparam int PERIOD = CLK_HZ / FREQ;
  localparam int TW     = $clog2(PERIOD + 1);
  localparam int CW     = (NSINK > 1) ? $clog2(NSINK) : 1;

  if (PERIOD < FLEN) begin : g_bad_period
    $error("pr3_frame_streamer: PERIOD must be >= 2^FFT");
  end

  // stage 1: every channel registered every cycle
  logic [NSINK-1:0][WIDTH-1:0] s1;

  for (genvar i = 0; i < NSINK; i++) begin : g_lane
    pr3_fs_lane #(.WIDTH(WIDTH)) u_lane (
      .clk40 (clk40),
      .reset (reset),
      .d     (sink[i]),
      .q     (s1[i])
    );
  end

  logic [TW-1:0] tcnt;
  logic          win;
  logic          sop_d, eop_d;
  logic [2:1]    vld_pipe;
  logic [CW-1:0] ch;
  logic          sop_q, eop_q;
  logic [31:0]   data_q;

  assign win = (tcnt < TW'(FLEN));

  always_ff @(posedge clk40) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (tcnt == TW'(PERIOD - 1)) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // beat flags travel alongside the stage-1 sample
  always_ff @(posedge clk40) begin
    if (!reset) begin
      vld_pipe[1] <= 1'b0;
      sop_d       <= 1'b0;
      eop_d       <= 1'b0;
    end else begin
      vld_pipe[1] <= win;
      sop_d       <= win && (tcnt == '0);
      eop_d       <= win && (tcnt == TW'(FLEN - 1));
    end
  end

  logic [WIDTH-1:0] sample;
  logic [15:0]      re_part;
  logic [15:0]      im_part;

  assign sample  = s1[ch];
  assign re_part = 16'($signed(sample));
`ifdef PR3_CHTAG_EN
  assign im_part = {8'h00, 8'(ch)};
`else
  assign im_part = 16'h0000;
`endif

  // stage 2: output register; channel steps only once its eop beat is out
  always_ff @(posedge clk40) begin
    if (!reset) begin
      vld_pipe[2] <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
      ch          <= '0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      data_q      <= vld_pipe[1] ? {re_part, im_part} : 32'h0;
      if (vld_pipe[1] && eop_d)
        ch <= (ch == CW'(NSINK - 1)) ? '0 : ch + 1'b1;
    end
  end

  assign src.source_valid = vld_pipe[2];
  assign src.source_sop   = sop_q;
  assign src.source_eop   = eop_q;
  assign src.source_data  = data_q;
endmodule

// File: tb/tb_pr3_frame_streamer.sv
// Scoreboard bench for pr3_frame_streamer: driver pushes expected beats, monitor pops on valid.
module tb_pr3_frame_streamer;
  localparam int NSINK  = 3;
  localparam int WIDTH  = 14;
  localparam int FFT    = 11;
  localparam int N      = 2048;
  localparam int PERIOD = 8000;

  logic clk40 = 1'b0;
  logic reset = 1'b0;
  logic signed [WIDTH-1:0] sink [0:NSINK-1];

  pr3_frame_streamer_if src_if ();

  pr3_frame_streamer #(
    .NSINK(NSINK), .WIDTH(WIDTH), .FFT(FFT), .FREQ(5000), .CLK_HZ(40000000)
  ) dut (
    .clk40 (clk40),
    .reset (reset),
    .sink  (sink),
    .src   (src_if)
  );

  always #5 clk40 = ~clk40;

  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk40) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  typedef struct {
    int          arr;
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   last_sop = -1;

  // reference model state
  int   m_tcnt = 0;
  int   m_ch   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // drive one cycle; w[] holds the hand-computed real part per channel
  task automatic step(input logic r, input logic [13:0] s0, input logic [13:0] s1v,
                      input logic [13:0] s2, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2);
    int   e;
    exp_t x;
    logic [31:0] w;
    reset   = r;
    sink[0] = s0;
    sink[1] = s1v;
    sink[2] = s2;
    e = cyc + 1;
    if (!r) begin
      while (q.size() > 0 && q[$].arr >= e) void'(q.pop_back());
      m_tcnt = 0;
      m_ch   = 0;
    end else begin
      if (m_tcnt < N) begin
        w = (m_ch == 0) ? w0 : (m_ch == 1) ? w1 : w2;
`ifdef PR3_CHTAG_EN
        w[7:0] = 8'(m_ch);
`endif
        x.arr  = e + 1;
        x.data = w;
        x.sop  = (m_tcnt == 0);
        x.eop  = (m_tcnt == N - 1);
        q.push_back(x);
        if (x.eop) m_ch = (m_ch + 1) % NSINK;
      end
      m_tcnt = (m_tcnt + 1) % PERIOD;
    end
    @(posedge clk40);
    #1;
  endtask

  // monitor
  always @(negedge clk40) begin
    if (mon_en) begin
      if (!rst_q) begin
        chk("rst_valid", 64'(src_if.source_valid), 64'd0);
        chk("rst_sop",   64'(src_if.source_sop),   64'd0);
        chk("rst_eop",   64'(src_if.source_eop),   64'd0);
        chk("rst_data",  64'(src_if.source_data),  64'd0);
        last_sop = -1;
      end else if (src_if.source_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat at cycle %0d: got valid data %h expected no beat",
                   cyc, src_if.source_data);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("beat_cycle", 64'(cyc), 64'(x.arr));
          chk("beat_data",  64'(src_if.source_data), 64'(x.data));
          chk("beat_sop",   64'(src_if.source_sop),  64'(x.sop));
          chk("beat_eop",   64'(src_if.source_eop),  64'(x.eop));
          if (src_if.source_sop) begin
            if (last_sop >= 0) chk("sop_interval", 64'(cyc - last_sop), 64'(PERIOD));
            last_sop = cyc;
          end
        end
      end else if (q.size() > 0 && q[0].arr <= cyc) begin
        exp_t x;
        x = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_beat at cycle %0d: got valid=0 expected beat data %h", cyc, x.data);
      end
    end
  end

  localparam logic [31:0] W0 = 32'hFFFB0000;
  localparam logic [31:0] W1 = 32'h1FFF0000;
  localparam logic [31:0] W2 = 32'hE0000000;

  initial begin
    sink[0] = '0;
    sink[1] = '0;
    sink[2] = '0;
    @(posedge clk40);
    #1;
    mon_en = 1'b1;
    // reset and idle
    for (int i = 0; i < 10; i++) step(1'b0, 14'h3FFB, 14'h1FFF, 14'h2000, W0, W1, W2);
    // four frames of constant data: channels 0,1,2,0
    for (int i = 0; i < 4 * PERIOD; i++) step(1'b1, 14'h3FFB, 14'h1FFF, 14'h2000, W0, W1, W2);
    // channel-1 frame truncated by reset where beat 1000 would appear
    for (int i = 0; i < 1001; i++) step(1'b1, 14'h3FFB, 14'h1FFF, 14'h2000, W0, W1, W2);
    for (int i = 0; i < 3; i++) step(1'b0, 14'h3FFB, 14'h1FFF, 14'h2000, W0, W1, W2);
    // ramp on channel 0: beat k must carry k
    for (int i = 0; i < PERIOD + N + 4; i++)
      step(1'b1, 14'(m_tcnt), 14'h1FFF, 14'h2000, {16'(m_tcnt), 16'h0000}, W1, W2);
    for (int i = 0; i < 10; i++) step(1'b1, 14'h0000, 14'h1FFF, 14'h2000, W0, W1, W2);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
